// File: rtl/pcpu_pkg.sv
// Shared types for the register-file debug arbiter: FSM state encoding and the
// latched debug request.
package pcpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        HALTED,
        READ,
        WRITE,
        RESP
    } regs_arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } dbg_reg_req_t;

endpackage

// File: rtl/regs_arb_port_mux.sv
// Combinational selection of pipeline or latched debug signals onto the
// register-file ports, keyed by the arbiter state.
module regs_arb_port_mux
    import pcpu_pkg::*;
(
    input  regs_arb_state_t state,
    input  dbg_reg_req_t    req,
    input  logic [4:0]      pl_rs1_addr,
    input  logic [4:0]      pl_rs2_addr,
    input  logic [4:0]      pl_wt_addr,
    input  logic [31:0]     pl_wt_data,
    input  logic            pl_reg_write,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    output logic [4:0]      rf_wt_addr,
    output logic [31:0]     rf_wt_data,
    output logic            rf_reg_write
);

    always_comb begin
        rf_rs1_addr  = '0;
        rf_rs2_addr  = '0;
        rf_wt_addr   = '0;
        rf_wt_data   = '0;
        rf_reg_write = 1'b0;
        case (state)
            RUN, DRAIN: begin
                rf_rs1_addr  = pl_rs1_addr;
                rf_rs2_addr  = pl_rs2_addr;
                rf_wt_addr   = pl_wt_addr;
                rf_wt_data   = pl_wt_data;
                rf_reg_write = pl_reg_write;
            end
            READ: rf_rs1_addr = req.addr;
            WRITE: begin
                // x0 is hardwired zero, so the write strobe is suppressed for it
                rf_wt_addr   = req.addr;
                rf_wt_data   = req.wdata;
                rf_reg_write = (req.addr != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regs_debug_arbiter.sv
// Shares the register file write port and Rs1 read port between the pipeline and
// a debug requester. Optional access counter: REGS_DEBUG_ARBITER_ACCESS_CNT_EN.
module regs_debug_arbiter
    import pcpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       pl_rs1_addr,
    input  logic [4:0]       pl_rs2_addr,
    input  logic [4:0]       pl_wt_addr,
    input  logic [31:0]      pl_wt_data,
    input  logic             pl_reg_write,
    output logic             pl_stall,
    input  logic             dbg_halt_req,
    output logic             dbg_halted,
    input  logic             dbg_req_valid,
    output logic             dbg_req_ready,
    input  logic             dbg_req_we,
    input  logic [4:0]       dbg_req_addr,
    input  logic [31:0]      dbg_req_wdata,
    output logic             dbg_rsp_valid,
    input  logic             dbg_rsp_ready,
    output logic [31:0]      dbg_rsp_rdata,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    output logic [4:0]       rf_wt_addr,
    output logic [31:0]      rf_wt_data,
    output logic             rf_reg_write,
    input  logic [31:0]      rf_rs1_data,
    output logic [CNT_W-1:0] dbg_access_cnt
);

    localparam int unsigned        DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    regs_arb_state_t    state, state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    dbg_reg_req_t       req;

    always_comb begin
        state_next = state;
        case (state)
            RUN:    if (dbg_halt_req) state_next = DRAIN;
            DRAIN:  if (drain_cnt == DRAIN_LAST) state_next = HALTED;
            // a pending request takes priority over a resume
            HALTED: if (dbg_req_valid) state_next = dbg_req_we ? WRITE : READ;
                    else if (!dbg_halt_req) state_next = RUN;
            READ, WRITE: state_next = RESP;
            RESP:   if (dbg_rsp_ready) state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            drain_cnt     <= '0;
            req           <= '0;
            dbg_halted    <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_rdata <= '0;
        end else begin
            state         <= state_next;
            drain_cnt     <= (state == DRAIN && state_next == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            dbg_halted    <= (state_next == HALTED) || (state_next == READ) ||
                             (state_next == WRITE)  || (state_next == RESP);
            dbg_rsp_valid <= (state_next == RESP);
            if (state == HALTED && dbg_req_valid)
                req <= '{we: dbg_req_we, addr: dbg_req_addr, wdata: dbg_req_wdata};
            if (state == READ)
                dbg_rsp_rdata <= (req.addr == '0) ? '0 : rf_rs1_data;
            else if (state == WRITE)
                dbg_rsp_rdata <= '0;
        end
    end

    // Stall rises combinationally with the halt request while still in RUN
    assign pl_stall      = (state != RUN) || (dbg_halt_req && !rst);
    assign dbg_req_ready = (state == HALTED);

    regs_arb_port_mux u_port_mux (
        .state        (state),
        .req          (req),
        .pl_rs1_addr  (pl_rs1_addr),
        .pl_rs2_addr  (pl_rs2_addr),
        .pl_wt_addr   (pl_wt_addr),
        .pl_wt_data   (pl_wt_data),
        .pl_reg_write (pl_reg_write),
        .rf_rs1_addr  (rf_rs1_addr),
        .rf_rs2_addr  (rf_rs2_addr),
        .rf_wt_addr   (rf_wt_addr),
        .rf_wt_data   (rf_wt_data),
        .rf_reg_write (rf_reg_write)
    );

`ifdef REGS_DEBUG_ARBITER_ACCESS_CNT_EN
    logic [CNT_W-1:0] access_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            access_cnt <= '0;
        else if (state == RESP && dbg_rsp_ready && access_cnt != '1)
            access_cnt <= access_cnt + CNT_W'(1);
    end

    assign dbg_access_cnt = access_cnt;
`else
    assign dbg_access_cnt = '0;
`endif

endmodule
